// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Arbiter and access sequencer for the single external 16-bit async SRAM.
//   It is shared by the display reader (port 0), the camera capture writer
//   (port 1) and the color-transform engine (port 2). At most one word access
//   is issued per cycle. Read data returns on a shared bus with a one-hot
//   per-port valid.
//
//   Optional feature: define SRAM_ARB_LOCK_EN to let a port lock the bus
//   across a multi-word pixel access. When it is undefined, iLock is ignored.
//
// Ports
//   clk, rst_n     clock (posedge) and asynchronous active-low reset
//   iReq[2:0]      per-port request (0 display, 1 capture, 2 transform)
//   iWe[2:0]       per-port direction, 1 = write
//   iAddr          per-port word address, port p at [p*ADDR_W +: ADDR_W]
//   iWdata         per-port write data, port p at [p*DATA_W +: DATA_W]
//   iLock[2:0]     per-port bus-lock request (lock build only)
//   oAck[2:0]      one-hot combinational grant (request accepted this cycle)
//   oRdata         registered read data, shared by all ports
//   oRvalid[2:0]   one-hot, oRdata valid for that port this cycle
//   oSRAM_OE_N     SRAM output enable, active low, registered
//   oSRAM_WE_N     SRAM write enable, active low, registered
//   oSRAM_ADDR     SRAM word address, registered
//   oSRAM_DATA     SRAM data bus, driven only during write access cycles
//   oDbgState      sequencer state, 0 = IDLE, 1 = ACCESS
//
// Handshake: a port holds iReq/iWe/iAddr/iWdata stable until it sees its
// oAck bit high in the same cycle; it may change or drop them the cycle after.
module sram_port_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          iReq,
  input  logic [2:0]          iWe,
  input  logic [3*ADDR_W-1:0] iAddr,
  input  logic [3*DATA_W-1:0] iWdata,
  input  logic [2:0]          iLock,
  output logic [2:0]          oAck,
  output logic [DATA_W-1:0]   oRdata,
  output logic [2:0]          oRvalid,
  output logic                oSRAM_OE_N,
  output logic                oSRAM_WE_N,
  output logic [ADDR_W-1:0]   oSRAM_ADDR,
  inout  wire  [DATA_W-1:0]   oSRAM_DATA,
  output logic                oDbgState
);

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  state_t              r_state;
  logic                r_rr;       // 0 favours port 1, 1 favours port 2
  logic                r_oe_n;
  logic                r_we_n;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [2:0]          r_tag;      // one-hot port of the access in flight
  logic [DATA_W-1:0]   r_rdata;
  logic [2:0]          r_rvalid;

  logic [2:0]          w_elig;
  logic [2:0]          w_gnt;
  logic                w_any;
  logic                w_rr_hold;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_we;

`ifdef SRAM_ARB_LOCK_EN
  logic                r_locked;
  logic [2:0]          r_owner;    // one-hot lock owner
  logic                w_owner_lock;

  assign w_owner_lock = |(iLock & r_owner);
  // While locked only the owner may be granted, even over port 0.
  assign w_elig       = r_locked ? (iReq & r_owner) : iReq;
  // rr_ptr freezes while locked but updates on the release-cycle grant.
  assign w_rr_hold    = r_locked & w_owner_lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked <= 1'b0;
      r_owner  <= 3'b000;
    end else if (r_locked) begin
      if (!w_owner_lock) r_locked <= 1'b0;
    end else if (|(w_gnt & iLock)) begin
      r_locked <= 1'b1;
      r_owner  <= w_gnt;
    end
  end
`else
  logic w_unused_lock;

  assign w_unused_lock = ^iLock;
  assign w_elig        = iReq;
  assign w_rr_hold     = 1'b0;
`endif

  // Port 0 has strict priority; ports 1 and 2 share by round-robin.
  always_comb begin
    w_gnt = 3'b000;
    if (rst_n) begin
      if (w_elig[0])                            w_gnt = 3'b001;
      else if (w_elig[1] && (!w_elig[2] || !r_rr)) w_gnt = 3'b010;
      else if (w_elig[2])                       w_gnt = 3'b100;
    end
  end

  assign oAck  = w_gnt;
  assign w_any = |w_gnt;

  always_comb begin
    w_addr  = iAddr[0 +: ADDR_W];
    w_wdata = iWdata[0 +: DATA_W];
    w_we    = iWe[0];
    case (w_gnt)
      3'b010: begin
        w_addr  = iAddr[ADDR_W +: ADDR_W];
        w_wdata = iWdata[DATA_W +: DATA_W];
        w_we    = iWe[1];
      end
      3'b100: begin
        w_addr  = iAddr[2*ADDR_W +: ADDR_W];
        w_wdata = iWdata[2*DATA_W +: DATA_W];
        w_we    = iWe[2];
      end
      default: ;
    endcase
  end

  // Sequencer: the grant edge registers the access; the following edge
  // captures read data for the tagged port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rr     <= 1'b0;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_tag    <= 3'b000;
      r_rdata  <= '0;
      r_rvalid <= 3'b000;
    end else begin
      r_state <= w_any ? S_ACCESS : S_IDLE;
      if (w_any) begin
        r_addr  <= w_addr;
        r_oe_n  <= w_we;
        r_we_n  <= ~w_we;
        r_wdata <= w_wdata;
        r_tag   <= w_gnt;
      end else begin
        r_oe_n  <= 1'b1;
        r_we_n  <= 1'b1;
      end

      if (w_gnt[1] && !w_rr_hold)      r_rr <= 1'b1;
      else if (w_gnt[2] && !w_rr_hold) r_rr <= 1'b0;

      if (r_state == S_ACCESS && !r_oe_n) begin
        r_rdata  <= oSRAM_DATA;
        r_rvalid <= r_tag;
      end else begin
        r_rvalid <= 3'b000;
      end
    end
  end

  assign oSRAM_DATA = r_we_n ? {DATA_W{1'bz}} : r_wdata;
  assign oSRAM_OE_N = r_oe_n;
  assign oSRAM_WE_N = r_we_n;
  assign oSRAM_ADDR = r_addr;
  assign oRdata     = r_rdata;
  assign oRvalid    = r_rvalid;
  assign oDbgState  = (r_state == S_ACCESS);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: table-driven arbitration vectors plus
// hand-written sequences for latency, write/read turnaround, lock and
// mid-access reset. A small SRAM model sits on the data bus; a shadow memory
// and an expected queue predict every oRvalid/oRdata pair.
module tb_sram_port_arbiter;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int EW     = 3 + DATA_W;

`ifdef SRAM_ARB_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]          iReq   = '0;
  logic [2:0]          iWe    = '0;
  logic [2:0]          iLock  = '0;
  logic [3*ADDR_W-1:0] iAddr  = '0;
  logic [3*DATA_W-1:0] iWdata = '0;
  logic [2:0]          oAck;
  logic [DATA_W-1:0]   oRdata;
  logic [2:0]          oRvalid;
  logic                sram_oe_n;
  logic                sram_we_n;
  logic [ADDR_W-1:0]   sram_addr;
  logic                dbg_state;
  tri1  [DATA_W-1:0]   sram_data;   // released bus reads as all ones

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .iReq(iReq), .iWe(iWe), .iAddr(iAddr),
    .iWdata(iWdata), .iLock(iLock), .oAck(oAck), .oRdata(oRdata),
    .oRvalid(oRvalid), .oSRAM_OE_N(sram_oe_n), .oSRAM_WE_N(sram_we_n),
    .oSRAM_ADDR(sram_addr), .oSRAM_DATA(sram_data), .oDbgState(dbg_state)
  );

  // ---------------- SRAM model ----------------
  logic              mem_init = 1'b0;
  logic [DATA_W-1:0] mem [512];

  function automatic logic [DATA_W-1:0] def_word(input int a);
    return (a == 16) ? 16'hBEEF : 16'h1000 + 16'(a);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= def_word(i);
    end else if (!sram_we_n) begin
      mem[sram_addr[8:0]] <= sram_data;
    end
  end

  assign sram_data = sram_oe_n ? {DATA_W{1'bz}} : mem[sram_addr[8:0]];

  // ---------------- scoreboard ----------------
  logic [EW-1:0]     exp_q [$];
  logic [DATA_W-1:0] exp_mem [512];
  logic [EW-1:0]     mon_e;
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every read-data return is matched against the oldest predicted read.
  always @(negedge clk) begin
    if (rst_n && oRvalid != 3'b000) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rvalid_unexpected: got rvalid 0x%0h, expected none", oRvalid);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_rvalid", {29'd0, oRvalid}, {29'd0, mon_e[EW-1 -: 3]});
        check("sb_rdata", {16'd0, oRdata}, {16'd0, mon_e[DATA_W-1:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_port(input int p, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    iAddr[p*ADDR_W +: ADDR_W]  = a;
    iWdata[p*DATA_W +: DATA_W] = d;
  endtask

  // Drive one cycle of requests and record the combinational grant; the
  // shadow memory is updated in grant order so predictions follow the bus.
  task automatic drive(input logic [2:0] req, input logic [2:0] we,
                       input logic [2:0] lock, output logic [2:0] ack);
    int a;
    logic [2:0] oh;
    @(negedge clk);
    iReq  = req;
    iWe   = we;
    iLock = lock;
    #1;
    ack = oAck;
    for (int p = 0; p < 3; p++) begin
      if (ack[p]) begin
        a  = int'(iAddr[p*ADDR_W +: 9]);
        oh = 3'b001 << p;
        if (we[p]) exp_mem[a] = iWdata[p*DATA_W +: DATA_W];
        else       exp_q.push_back({oh, exp_mem[a]});
      end
    end
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] we;
    logic [2:0] exp_ack;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [2:0] ack;

    // Round-robin table; rr favours port 1 on entry.
    vecs[0]  = '{3'b110, 3'b000, 3'b010};
    vecs[1]  = '{3'b110, 3'b000, 3'b100};
    vecs[2]  = '{3'b111, 3'b000, 3'b001};
    vecs[3]  = '{3'b110, 3'b000, 3'b010};
    vecs[4]  = '{3'b110, 3'b000, 3'b100};
    vecs[5]  = '{3'b110, 3'b000, 3'b010};
    vecs[6]  = '{3'b110, 3'b000, 3'b100};
    vecs[7]  = '{3'b100, 3'b000, 3'b100};
    vecs[8]  = '{3'b010, 3'b010, 3'b010};
    vecs[9]  = '{3'b011, 3'b000, 3'b001};
    vecs[10] = '{3'b110, 3'b000, 3'b100};
    vecs[11] = '{3'b010, 3'b000, 3'b010};
    vecs[12] = '{3'b000, 3'b000, 3'b000};

    for (int i = 0; i < 512; i++) exp_mem[i] = def_word(i);

    // Reset with all ports requesting.
    mem_init = 1'b1;
    iReq     = 3'b111;
    set_port(0, 20'h00020, 16'h0000);
    set_port(1, 20'h00030, 16'hA511);
    set_port(2, 20'h00040, 16'h0000);
    repeat (3) @(negedge clk);
    #1;
    check("rst_ack", {29'd0, oAck}, 32'd0);
    check("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_addr", {12'd0, sram_addr}, 32'd0);
    check("rst_bus_released", {16'd0, sram_data}, 32'h0000FFFF);
    check("rst_rdata", {16'd0, oRdata}, 32'd0);
    check("rst_rvalid", {29'd0, oRvalid}, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);
    mem_init = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    drive(3'b111, 3'b000, 3'b000, ack);
    check("release_ack_p0", {29'd0, ack}, 32'h1);
    drive(3'b000, 3'b000, 3'b000, ack);
    check("release_addr", {12'd0, sram_addr}, 32'h20);
    check("release_oe_n", {31'd0, sram_oe_n}, 32'd0);
    drive(3'b000, 3'b000, 3'b000, ack);

    // Read latency: port 2 reads 0x00010.
    set_port(2, 20'h00010, 16'h0000);
    drive(3'b100, 3'b000, 3'b000, ack);
    check("lat_ack", {29'd0, ack}, 32'h4);
    drive(3'b000, 3'b000, 3'b000, ack);
    check("lat_addr_t1", {12'd0, sram_addr}, 32'h10);
    check("lat_oe_n_t1", {31'd0, sram_oe_n}, 32'd0);
    check("lat_we_n_t1", {31'd0, sram_we_n}, 32'd1);
    check("lat_state_t1", {31'd0, dbg_state}, 32'd1);
    drive(3'b000, 3'b000, 3'b000, ack);
    check("lat_rvalid_t2", {29'd0, oRvalid}, 32'h4);
    check("lat_rdata_t2", {16'd0, oRdata}, 32'hBEEF);
    check("lat_oe_n_t2", {31'd0, sram_oe_n}, 32'd1);
    check("lat_state_t2", {31'd0, dbg_state}, 32'd0);
    drive(3'b000, 3'b000, 3'b000, ack);
    check("idle_addr_hold", {12'd0, sram_addr}, 32'h10);
    check("idle_rvalid", {29'd0, oRvalid}, 32'd0);
    check("idle_rdata_hold", {16'd0, oRdata}, 32'hBEEF);

    // Round-robin / priority table.
    set_port(2, 20'h00040, 16'h0000);
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].req, vecs[i].we, 3'b000, ack);
      check($sformatf("rr_vec%0d_ack", i), {29'd0, ack}, {29'd0, vecs[i].exp_ack});
    end

    // Write then read the same address with no bubble.
    set_port(1, 20'h00100, 16'h1234);
    set_port(2, 20'h00100, 16'h0000);
    drive(3'b010, 3'b010, 3'b000, ack);
    check("wr_ack", {29'd0, ack}, 32'h2);
    drive(3'b100, 3'b000, 3'b000, ack);
    check("rd_ack", {29'd0, ack}, 32'h4);
    check("wr_we_n", {31'd0, sram_we_n}, 32'd0);
    check("wr_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("wr_bus", {16'd0, sram_data}, 32'h1234);
    check("wr_addr", {12'd0, sram_addr}, 32'h100);
    drive(3'b000, 3'b000, 3'b000, ack);
    check("rd_oe_n", {31'd0, sram_oe_n}, 32'd0);
    check("rd_we_n", {31'd0, sram_we_n}, 32'd1);
    drive(3'b000, 3'b000, 3'b000, ack);
    check("wr_rd_rvalid", {29'd0, oRvalid}, 32'h4);
    check("wr_rd_rdata", {16'd0, oRdata}, 32'h1234);
    check("bus_released", {16'd0, sram_data}, 32'h0000FFFF);

    // Lock: port 2 locks for two reads while port 0 requests.
    set_port(0, 20'h00020, 16'h0000);
    set_port(2, 20'h00010, 16'h0000);
    drive(3'b100, 3'b000, 3'b100, ack);
    check("lock_c1_ack", {29'd0, ack}, 32'h4);
    drive(3'b101, 3'b000, 3'b100, ack);
    check("lock_c2_ack", {29'd0, ack}, LOCK_ON ? 32'h4 : 32'h1);
    drive(3'b001, 3'b000, 3'b000, ack);
    check("lock_c3_ack", {29'd0, ack}, LOCK_ON ? 32'h0 : 32'h1);
    drive(3'b001, 3'b000, 3'b000, ack);
    check("lock_c4_ack", {29'd0, ack}, 32'h1);
    drive(3'b000, 3'b000, 3'b000, ack);
    drive(3'b000, 3'b000, 3'b000, ack);

    // Mid-access reset: port 1 locks and reads, reset lands in the access.
    set_port(1, 20'h00030, 16'h0000);
    drive(3'b010, 3'b000, 3'b010, ack);
    check("mid_g1_ack", {29'd0, ack}, 32'h2);
    drive(3'b010, 3'b000, 3'b010, ack);
    check("mid_g2_ack", {29'd0, ack}, 32'h2);
    drive(3'b000, 3'b000, 3'b010, ack);
    check("mid_pre_oe_n", {31'd0, sram_oe_n}, 32'd0);
    iReq = 3'b011;
    #1 rst_n = 1'b0;
    #1;
    check("mid_oe_n_async", {31'd0, sram_oe_n}, 32'd1);
    check("mid_we_n_async", {31'd0, sram_we_n}, 32'd1);
    check("mid_ack_forced", {29'd0, oAck}, 32'd0);
    check("mid_rvalid", {29'd0, oRvalid}, 32'd0);
    check("mid_addr", {12'd0, sram_addr}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    iLock = 3'b000;
    drive(3'b011, 3'b000, 3'b000, ack);
    check("mid_lock_cleared", {29'd0, ack}, 32'h1);
    drive(3'b110, 3'b000, 3'b000, ack);
    check("mid_rr_reset", {29'd0, ack}, 32'h2);
    for (int i = 0; i < 3; i++) begin
      drive(3'b000, 3'b000, 3'b000, ack);
    end
    check("idle_state", {31'd0, dbg_state}, 32'd0);
    check("idle_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("idle_we_n", {31'd0, sram_we_n}, 32'd1);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Three-port arbiter and access sequencer for the single external 16-bit async SRAM. It shares the SRAM between the display reader, the camera capture writer and the color-transform engine. It owns the SRAM control, address and data pins outright; no other block drives them. It issues at most one SRAM word access per cycle, routes read data back to the requesting port, and optionally lets a port lock the bus across a multi-word pixel access.

## Interface
Parameters:
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, SRAM data width

Ports:
- clk  input  1  system clock; all logic on posedge
- rst_n  input  1  asynchronous, active-low reset
- iReq  input  3  per-port request; bit 0 display, bit 1 capture, bit 2 transform
- iWe  input  3  per-port direction; 1 write, 0 read
- iAddr  input  3*ADDR_W  per-port word address; port p at [p*ADDR_W +: ADDR_W]
- iWdata  input  3*DATA_W  per-port write data
- iLock  input  3  per-port bus-lock request (SRAM_ARB_LOCK_EN only)
- oAck  output  3  one-hot, combinational; request accepted this cycle
- oRdata  output  DATA_W  registered read data, shared by all ports
- oRvalid  output  3  one-hot; oRdata valid for that port this cycle
- oSRAM_OE_N  output  1  SRAM output enable, active low, registered
- oSRAM_WE_N  output  1  SRAM write enable, active low, registered
- oSRAM_ADDR  output  ADDR_W  SRAM address, registered
- oSRAM_DATA  inout  DATA_W  SRAM data bus; driven only in write access cycles, else high-Z

## Operation
- Request handshake: a port holds iReq, iWe, iAddr and iWdata stable until it sees oAck high in the same cycle. The port may change or drop them in the next cycle.
- Arbitration is combinational over iReq, with at most one oAck bit set per cycle.
- Priority when no lock is held:
  - Port 0 wins whenever it requests.
  - Otherwise ports 1 and 2 are round-robin. rr_ptr selects the favoured port.
  - rr_ptr flips to the non-granted port only when port 1 or port 2 is granted.
  - rr_ptr resets to favour port 1.
- Sequencer state: IDLE when no access is issued, ACCESS when an access is registered for this cycle.
  - IDLE -> ACCESS on any oAck.
  - ACCESS -> ACCESS on a back-to-back oAck, else -> IDLE.
- Registered on the grant edge:
  - oSRAM_ADDR <= iAddr[p].
  - oSRAM_OE_N <= iWe[p].
  - oSRAM_WE_N <= ~iWe[p].
  - Write-data register <= iWdata[p].
  - Tag <= p.
- In IDLE: OE_N = 1, WE_N = 1, oSRAM_ADDR holds its last value, bus high-Z.
- Read capture: at the end of the access cycle, oRdata <= oSRAM_DATA and oRvalid[tag] <= 1 for one cycle.
- Writes produce no oRvalid.
- oRdata holds its value until the next read capture.

## Timing
- Reset values:
  - oSRAM_OE_N = 1, oSRAM_WE_N = 1, oSRAM_ADDR = 0, oSRAM_DATA high-Z.
  - oRdata = 0, oRvalid = 0.
  - oAck forced to 0 while rst_n is low.
  - Lock released; rr_ptr favours port 1.
- Latency, with grant in cycle T:
  - SRAM access in cycle T+1.
  - oRvalid high in cycle T+2.
  - Throughput is one access per cycle, including read->write and write->read with no bubble.
- Same-port back-to-back grants are allowed. Tags pipeline so that oRvalid stays in order.
- Reset asserted mid-access: OE_N and WE_N go high immediately (async). An in-flight read produces no oRvalid. The requester must reissue after reset.
- No requests: state stays IDLE; no outputs toggle except oRvalid draining.
- Address range is not checked; out-of-range addresses wrap per ADDR_W.

## Configuration
- SRAM_ARB_LOCK_EN defined:
  - A grant to port p with iLock[p] = 1 makes p the lock owner.
  - While locked, only the owner is eligible, overriding port-0 priority. An owner cycle with iReq low leaves the bus idle.
  - The lock is released on the first posedge where iLock[owner] = 0. A grant in that same cycle still goes to the owner.
  - rr_ptr does not update while locked. It updates on the release grant as normal.
- SRAM_ARB_LOCK_EN undefined: iLock is ignored, no lock state is synthesized, and pure priority/round-robin applies.

## Test plan
- Reset: hold rst_n low with iReq = 3'b111 -> oAck = 0, OE_N = WE_N = 1, ADDR = 0, bus Z; release -> port 0 acked on the first cycle.
- Read latency: port 2 reads 0x00010, SRAM model returns 0xBEEF -> oAck[2] at T, ADDR = 0x00010 and OE_N = 0 at T+1, oRvalid = 3'b100 and oRdata = 0xBEEF at T+2.
- Round-robin: ports 1 and 2 requesting continuously for 6 cycles -> grants alternate 1,2,1,2,1,2. Port 0 asserted in cycle 3 -> port 0 granted in cycle 3 and alternation resumes.
- Write then read, same address: port 1 writes 0x1234 to 0x00100, then port 2 reads 0x00100 back-to-back -> WE_N low with data 0x1234 driven in one cycle, bus Z next cycle, oRdata = 0x1234 with oRvalid[2].
- Lock (SRAM_ARB_LOCK_EN): port 2 holds iLock for 2 reads while port 0 requests -> port 2 gets 2 consecutive grants, port 0 granted the cycle after iLock drops. Without the macro, port 0 wins immediately.
- Mid-access reset: rst_n pulses low during a read access cycle -> OE_N = 1 asynchronously, no oRvalid pulse, lock cleared.
